// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder. Each operation takes WIDTH cycles
// and processes one bit per clock, LSB first.
//
// Ports:
//   ck     - clock. All state updates on the rising edge.
//   rst    - asynchronous active-low reset.
//   start  - begin an operation. Accepted only while idle, including the
//            cycle in which done is high.
//   a, b   - operands, captured when start is accepted.
//   ci     - carry-in, captured when start is accepted.
//   sub    - subtract request, captured when start is accepted.
//   s, co  - registered result and carry-out. These update only on
//            completion or reset.
//   busy   - an operation is in progress.
//   done   - one-cycle pulse that marks s/co as fresh.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN. When it is defined, sub=1
// selects a - b: B is inverted as it is loaded and the carry is preset to 1.
// Without the macro, sub is accepted and ignored.

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             done_q, done_d;

    // Operand B and the carry as they enter the datapath at the accepting edge.
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
    // a - b = a + ~b + 1. In this mode the carry flop holds "no borrow".
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : ci;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_load     = b;
    assign c_load     = ci;
`endif

    // One full-adder slice, applied to the LSBs of the shift registers.
    logic sum_bit, carry_nxt, last_bit;
    assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    assign last_bit  = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        s_d     = s_q;
        carry_d = carry_q;
        co_d    = co_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_load;
                    carry_d = c_load;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = carry_nxt;
                // Sum bits enter at the MSB. After WIDTH shifts, bit 0 is at the LSB.
                res_d   = {sum_bit, res_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    s_d     = {sum_bit, res_q[WIDTH-1:1]};
                    co_d    = carry_nxt;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            done_q  <= done_d;
        end
    end

    assign s    = s_q;
    assign co   = co_q;
    assign busy = (state_q == RUN);
    assign done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic       ck = 1'b0;
    logic       rst = 1'b0;

    logic       start8 = 1'b0, ci8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [7:0] s8;
    logic       co8, busy8, done8;

    logic       start4 = 1'b0, ci4 = 1'b0, sub4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [3:0] s4;
    logic       co4, busy4, done4;

    int errors = 0;
    int checks = 0;

    always #5 ck = ~ck;

    serial_adder #(.WIDTH(8)) dut8 (
        .ck(ck), .rst(rst), .start(start8), .a(a8), .b(b8), .ci(ci8), .sub(sub8),
        .s(s8), .co(co8), .busy(busy8), .done(done8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .ck(ck), .rst(rst), .start(start4), .a(a4), .b(b4), .ci(ci4), .sub(sub4),
        .s(s4), .co(co4), .busy(busy4), .done(done4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Transaction-level view: an accepted start yields the arithmetic result
    // exactly w cycles later. Until then the outputs hold their previous values.
    logic        m_busy [2];
    logic        m_done [2];
    int          m_left [2];
    logic [31:0] m_s    [2];
    logic        m_co   [2];
    logic [31:0] p_s    [2];
    logic        p_co   [2];

    function automatic logic [32:0] model_sum(int w, logic [31:0] a, logic [31:0] b,
                                               logic ci, logic sub);
        logic [32:0] m, r;
        logic subm;
        m = (33'd1 << w) - 33'd1;
`ifdef SERIAL_ADDER_SUB_EN
        subm = sub;
`else
        subm = 1'b0;
`endif
        if (subm) r = {1'b0, a} + ((~{1'b0, b}) & m) + 33'd1;
        else      r = {1'b0, a} + {1'b0, b} + {32'd0, ci};
        return r;
    endfunction

    task automatic step(int i, int w, logic st, logic [31:0] a, logic [31:0] b,
                        logic ci, logic sub);
        logic [32:0] r, m;
        m = (33'd1 << w) - 33'd1;
        if (m_busy[i]) begin
            m_left[i]--;
            if (m_left[i] == 0) begin
                m_busy[i] = 1'b0;
                m_done[i] = 1'b1;
                m_s[i]    = p_s[i];
                m_co[i]   = p_co[i];
            end
        end else begin
            m_done[i] = 1'b0;
            if (st) begin
                r         = model_sum(w, a, b, ci, sub);
                p_s[i]    = r[31:0] & m[31:0];
                p_co[i]   = r[w];
                m_busy[i] = 1'b1;
                m_left[i] = w;
            end
        end
    endtask

    always @(posedge ck or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 1'b0; m_done[i] = 1'b0; m_left[i] = 0;
                m_s[i] = '0; m_co[i] = 1'b0; p_s[i] = '0; p_co[i] = 1'b0;
            end
        end else begin
            step(0, 8, start8, {24'd0, a8}, {24'd0, b8}, ci8, sub8);
            step(1, 4, start4, {28'd0, a4}, {28'd0, b4}, ci4, sub4);
        end
    end

    // Cycle-by-cycle comparison, sampled mid-cycle.
    always @(negedge ck) begin
        chk("m8_s",    {24'd0, s8},    m_s[0]);
        chk("m8_co",   {31'd0, co8},   {31'd0, m_co[0]});
        chk("m8_busy", {31'd0, busy8}, {31'd0, m_busy[0]});
        chk("m8_done", {31'd0, done8}, {31'd0, m_done[0]});
        chk("m4_s",    {28'd0, s4},    m_s[1]);
        chk("m4_co",   {31'd0, co4},   {31'd0, m_co[1]});
        chk("m4_busy", {31'd0, busy4}, {31'd0, m_busy[1]});
        chk("m4_done", {31'd0, done4}, {31'd0, m_done[1]});
    end

    // ---------------- directed stimulus ----------------
    // The caller has already presented start. This task waits past E0,
    // scrambles the inputs, and then checks latency, s hold and the result.
    task automatic finish8(input string tag, input logic [7:0] es, input logic ec);
        logic [7:0] prev;
        int n;
        @(negedge ck);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); sub8 = 1'($urandom);
        prev = s8;
        n = 0;
        while (!done8 && n < 20) begin
            @(posedge ck); #1;
            n++;
            if (!done8) chk({tag, "_s_hold"}, {24'd0, s8}, {24'd0, prev});
        end
        chk({tag, "_latency"}, n, 8);
        chk({tag, "_s"},  {24'd0, s8},  {24'd0, es});
        chk({tag, "_co"}, {31'd0, co8}, {31'd0, ec});
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic sub, input logic [7:0] es, input logic ec);
        @(negedge ck);
        start8 = 1'b1; a8 = a; b8 = b; ci8 = ci; sub8 = sub;
        finish8(tag, es, ec);
    endtask

    logic [3:0] ea4 [4] = '{4'd1, 4'd9, 4'd15, 4'd0};
    logic [3:0] eb4 [4] = '{4'd2, 4'd8, 4'd15, 4'd0};
    logic [3:0] es4 [4] = '{4'd3, 4'd1, 4'd14, 4'd0};
    logic       ec4 [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int n, dones;
        repeat (2) @(negedge ck);
        chk("rst_s",    {24'd0, s8},    32'd0);
        chk("rst_co",   {31'd0, co8},   32'd0);
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);

        // Start coincides with the release of reset.
        @(negedge ck);
        rst = 1'b1;
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0; sub8 = 1'b0;
        finish8("r028", 8'h00, 1'b1);

        op8("r029",  8'h5A, 8'h3C, 1'b1, 1'b0, 8'h97, 1'b0);
        op8("add_c", 8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1);
        op8("zero",  8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
        op8("r030a", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        op8("r030b", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0);
        op8("sub_ci", 8'h33, 8'h33, 1'b1, 1'b1, 8'h00, 1'b1);
`else
        op8("r030a", 8'h10, 8'h01, 1'b0, 1'b1, 8'h11, 1'b0);
        op8("r030b", 8'h01, 8'h02, 1'b0, 1'b1, 8'h03, 1'b0);
        op8("sub_ci", 8'h33, 8'h33, 1'b1, 1'b1, 8'h67, 1'b0);
`endif

        // A start at E3 with new operands is ignored.
        @(negedge ck);
        start8 = 1'b1; a8 = 8'h21; b8 = 8'h12; ci8 = 1'b0; sub8 = 1'b0;
        @(negedge ck); start8 = 1'b0;
        @(negedge ck);
        @(negedge ck); start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
        @(negedge ck); start8 = 1'b0;
        dones = 0;
        repeat (14) begin @(negedge ck); if (done8) dones++; end
        chk("r031_dones", dones, 1);
        chk("r031_s",  {24'd0, s8},  32'h33);
        chk("r031_co", {31'd0, co8}, 32'd0);

        // Reset between E4 and E5.
        @(negedge ck);
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; ci8 = 1'b1;
        @(negedge ck); start8 = 1'b0;
        repeat (4) @(negedge ck);
        #2 rst = 1'b0;
        #1;
        chk("r032_s",    {24'd0, s8},    32'd0);
        chk("r032_co",   {31'd0, co8},   32'd0);
        chk("r032_busy", {31'd0, busy8}, 32'd0);
        chk("r032_done", {31'd0, done8}, 32'd0);
        @(negedge ck); rst = 1'b1;
        dones = 0;
        repeat (12) begin @(negedge ck); if (done8) dones++; end
        chk("r032_nodone", dones, 0);
        op8("r032_after", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);

        // WIDTH=4 with start held high: done every 5 cycles.
        @(negedge ck);
        start4 = 1'b1; a4 = ea4[0]; b4 = eb4[0];
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin @(negedge ck); n++; end while (!done4 && n < 12);
            chk($sformatf("r033_period%0d", k), n, 5);
            chk($sformatf("r033_s%0d", k),  {28'd0, s4},  {28'd0, es4[k]});
            chk($sformatf("r033_co%0d", k), {31'd0, co4}, {31'd0, ec4[k]});
            if (k < 3) begin a4 = ea4[k+1]; b4 = eb4[k+1]; end
        end
        start4 = 1'b0;
        repeat (8) @(negedge ck);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: ck  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request to begin an operation, sampled on rising ck.
REQ-005 SHALL have port: a  input  WIDTH  operand A, captured when start accepted.
REQ-006 SHALL have port: b  input  WIDTH  operand B, captured when start accepted.
REQ-007 SHALL have port: ci  input  1  carry-in, captured when start accepted.
REQ-008 SHALL have port: sub  input  1  subtract-mode request, captured when start accepted (see Configuration).
REQ-009 SHALL have port: s  output  WIDTH  registered result.
REQ-010 SHALL have port: co  output  1  registered carry-out of the result.
REQ-011 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-012 SHALL have port: done  output  1  one-cycle pulse, result valid.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and RUN, plus a bit counter of ceil(log2(WIDTH+1)) bits.
REQ-014 SHALL accept start only in IDLE; at the accepting edge E0: capture a, b into shift registers, load carry flop with ci, clear counter, enter RUN, busy=1.
REQ-015 SHALL, at edge Ek (k=1..WIDTH) in RUN, process operand bit k-1 LSB-first: sum bit = A^B^carry, carry = majority(A,B,carry), sum bit shifted into an internal result register.
REQ-016 SHALL, at edge E_WIDTH: load s with the full internal result, co with final carry, set done=1, busy=0, return to IDLE.
REQ-017 SHALL hold done high for exactly one cycle; done and busy SHALL never be high simultaneously.
REQ-018 SHALL keep s and co unchanged during RUN; they change only at completion or reset.
REQ-019 SHALL ignore start while in RUN (no restart, no operand recapture).
REQ-020 SHALL accept start in the cycle done is high (back-to-back operations, WIDTH+1 edges apart minimum).
REQ-021 SHALL ignore a, b, ci, sub changes after E0 until the operation completes.
REQ-022 SHALL produce s = (a + b + ci) mod 2^WIDTH, co = bit WIDTH of that sum, in add mode.

Reset
REQ-023 SHALL, while rst=0, immediately force: FSM=IDLE, counter=0, carry=0, shift/result registers=0, s=0, co=0, busy=0, done=0.
REQ-024 SHALL abort any operation on reset mid-RUN with no partial result reaching s or co.
REQ-025 SHALL accept start at the first rising edge after rst deasserts.

Configuration
REQ-026 SHALL, with SERIAL_ADDER_SUB_EN defined, honour sub: when sub=1 at E0, B is inverted as loaded and carry flop loaded with 1 (ci ignored), giving s = (a - b) mod 2^WIDTH, co = 1 when no borrow (a >= b unsigned).
REQ-027 SHALL, without SERIAL_ADDER_SUB_EN, keep the sub port but ignore it; all operations are add mode and no inversion logic is synthesised.

Verification
REQ-028 SHALL cover, WIDTH=8: a=0xFF, b=0x01, ci=0, start -> done exactly 8 edges after E0, s=0x00, co=1.
REQ-029 SHALL cover, WIDTH=8: a=0x5A, b=0x3C, ci=1 -> s=0x97, co=0; s holds prior value throughout RUN.
REQ-030 SHALL cover, WIDTH=8 with SERIAL_ADDER_SUB_EN: sub=1, a=0x10, b=0x01 -> s=0x0F, co=1; a=0x01, b=0x02 -> s=0xFF, co=0; same stimulus without macro -> s=0x11, co=0 and s=0x03, co=0 (ci=0).
REQ-031 SHALL cover: start pulsed again at edge E3 of a running operation with different operands -> ignored, first result unchanged, single done pulse.
REQ-032 SHALL cover: rst driven low between E4 and E5 -> s=0x00, co=0, busy=0, done=0 asynchronously; no done afterwards; new start after release completes normally.
REQ-033 SHALL cover: start held high continuously, WIDTH=4 -> done every 5 cycles, operands recaptured each time done is high.
